// File: rtl/imm_pkg.sv
// Shared immediate-format codes and RV opcode constants.
package imm_pkg;

    localparam int unsigned OPC_W = 7;
    localparam int unsigned FMT_W = 3;

    typedef enum logic [FMT_W-1:0] {
        FMT_R   = 3'd0,
        FMT_I   = 3'd1,
        FMT_S   = 3'd2,
        FMT_B   = 3'd3,
        FMT_U   = 3'd4,
        FMT_J   = 3'd5,
        FMT_SH  = 3'd6,
        FMT_BAD = 3'd7
    } imm_fmt_e;

    localparam logic [OPC_W-1:0] OPC_LOAD      = 7'b0000011;
    localparam logic [OPC_W-1:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [OPC_W-1:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [OPC_W-1:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [OPC_W-1:0] OPC_STORE     = 7'b0100011;
    localparam logic [OPC_W-1:0] OPC_OP        = 7'b0110011;
    localparam logic [OPC_W-1:0] OPC_LUI       = 7'b0110111;
    localparam logic [OPC_W-1:0] OPC_OP_32     = 7'b0111011;
    localparam logic [OPC_W-1:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [OPC_W-1:0] OPC_JALR      = 7'b1100111;
    localparam logic [OPC_W-1:0] OPC_JAL       = 7'b1101111;
    localparam logic [OPC_W-1:0] OPC_SYSTEM    = 7'b1110011;

endpackage

// File: rtl/imm_decode.sv
// Combinational immediate decoder: instruction word -> extended immediate and format.
module imm_decode
    import imm_pkg::*;
#(
    parameter int unsigned XLEN = 64
) (
    input  logic [31:0]     instruction,
    output logic [XLEN-1:0] immediate,
    output imm_fmt_e        fmt,
    output logic            illegal
);

    logic [OPC_W-1:0] opcode;
    logic             is_shift;

    assign opcode   = instruction[6:0];
    assign is_shift = (instruction[13:12] == 2'b01);
    assign illegal  = (fmt == FMT_BAD);

    // Select format by opcode and build the matching sign/zero-extended immediate.
    always_comb begin
        immediate = '0;
        fmt       = FMT_BAD;
        case (opcode)
            OPC_LOAD, OPC_JALR, OPC_SYSTEM: begin
                fmt       = FMT_I;
                immediate = XLEN'($signed(instruction[31:20]));
            end
            OPC_OP_IMM: begin
                if (is_shift) begin
                    fmt       = FMT_SH;
                    immediate = (XLEN == 64) ? XLEN'(instruction[25:20])
                                             : XLEN'(instruction[24:20]);
                end else begin
                    fmt       = FMT_I;
                    immediate = XLEN'($signed(instruction[31:20]));
                end
            end
            OPC_OP_IMM_32: begin
                if (XLEN == 64) begin
                    if (is_shift) begin
                        fmt       = FMT_SH;
                        immediate = XLEN'(instruction[24:20]);
                    end else begin
                        fmt       = FMT_I;
                        immediate = XLEN'($signed(instruction[31:20]));
                    end
                end
            end
            OPC_STORE: begin
                fmt       = FMT_S;
                immediate = XLEN'($signed({instruction[31:25], instruction[11:7]}));
            end
            OPC_BRANCH: begin
                fmt       = FMT_B;
                immediate = XLEN'($signed({instruction[31], instruction[7],
                                           instruction[30:25], instruction[11:8], 1'b0}));
            end
            OPC_LUI, OPC_AUIPC: begin
                fmt       = FMT_U;
                immediate = XLEN'($signed({instruction[31:12], 12'b0}));
            end
            OPC_JAL: begin
                fmt       = FMT_J;
                immediate = XLEN'($signed({instruction[31], instruction[19:12],
                                           instruction[20], instruction[30:21], 1'b0}));
            end
            OPC_OP: begin
                fmt = FMT_R;
            end
            OPC_OP_32: begin
                if (XLEN == 64) fmt = FMT_R;
            end
            default: begin
                fmt = FMT_BAD;
            end
        endcase
    end

endmodule

// File: rtl/imm_extend_pipe.sv
// Immediate extractor with a 2-entry output FIFO and illegal-opcode counter.
// Slot 0 is always the head and is kept zeroed while empty, so outputs come
// straight from registers and read 0 when nothing is valid.
module imm_extend_pipe
    import imm_pkg::*;
#(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instruction,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  immediate,
    output logic [FMT_W-1:0] imm_fmt,
    output logic             illegal,
    output logic [CNT_W-1:0] illegal_cnt
);

    logic [XLEN-1:0] dec_imm;
    imm_fmt_e        dec_fmt;
    logic            dec_bad;

    logic [XLEN-1:0] imm_q [2];
    imm_fmt_e        fmt_q [2];
    logic            bad_q [2];
    logic [1:0]      count_q;
    logic [CNT_W-1:0] cnt_q;

    logic push;
    logic pop;

    imm_decode #(.XLEN(XLEN)) u_decode (
        .instruction (instruction),
        .immediate   (dec_imm),
        .fmt         (dec_fmt),
        .illegal     (dec_bad)
    );

    assign in_ready    = (count_q != 2'd2);
    assign out_valid   = (count_q != 2'd0);
    assign push        = in_valid && in_ready;
    assign pop         = out_valid && out_ready;
    assign immediate   = imm_q[0];
    assign imm_fmt     = fmt_q[0];
    assign illegal     = bad_q[0];
    assign illegal_cnt = cnt_q;

    // FIFO storage, occupancy and saturating illegal counter; reset beats flush beats push/pop.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q  <= 2'd0;
            cnt_q    <= '0;
            imm_q[0] <= '0;
            fmt_q[0] <= FMT_R;
            bad_q[0] <= 1'b0;
            imm_q[1] <= '0;
            fmt_q[1] <= FMT_R;
            bad_q[1] <= 1'b0;
        end else if (flush) begin
            count_q  <= 2'd0;
            imm_q[0] <= '0;
            fmt_q[0] <= FMT_R;
            bad_q[0] <= 1'b0;
        end else begin
            if (pop && bad_q[0] && (cnt_q != {CNT_W{1'b1}})) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            case ({push, pop})
                2'b10: begin
                    if (count_q == 2'd0) begin
                        imm_q[0] <= dec_imm;
                        fmt_q[0] <= dec_fmt;
                        bad_q[0] <= dec_bad;
                    end else begin
                        imm_q[1] <= dec_imm;
                        fmt_q[1] <= dec_fmt;
                        bad_q[1] <= dec_bad;
                    end
                    count_q <= count_q + 2'd1;
                end
                2'b01: begin
                    if (count_q == 2'd2) begin
                        imm_q[0] <= imm_q[1];
                        fmt_q[0] <= fmt_q[1];
                        bad_q[0] <= bad_q[1];
                    end else begin
                        imm_q[0] <= '0;
                        fmt_q[0] <= FMT_R;
                        bad_q[0] <= 1'b0;
                    end
                    count_q <= count_q - 2'd1;
                end
                2'b11: begin
                    // Only reachable at count 1: new entry replaces the departing head.
                    imm_q[0] <= dec_imm;
                    fmt_q[0] <= dec_fmt;
                    bad_q[0] <= dec_bad;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
